// File: rtl/skipseq_pkg.sv
// Shared constants and width helpers for the skipseq pulse swallower.
package skipseq_pkg;

  localparam int unsigned PHASE0 = 0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Channel select stays at least one bit wide even for a single channel.
  function automatic int unsigned chw_of(input int unsigned nch);
    return (nch > 1) ? clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/skipseq_chan.sv
// One skip channel: double-buffered mask (shadow/pending/active) and the skip decision.
module skipseq_chan import skipseq_pkg::*; #(
  parameter int unsigned LEN = 16,
  parameter int unsigned LW  = clog2(LEN)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_wr,
  input  logic           i_wrap,
  input  logic           i_bypass,
  input  logic           i_e,
  input  logic [LEN-1:0] i_mask,
  input  logic [LW-1:0]  i_pos,
  output logic           o_skip,
  output logic           o_committed
);

  logic [LEN-1:0] r_shd;
  logic [LEN-1:0] r_act;
  logic           r_pend;

  // A write landing on the wrap edge goes straight to the active mask.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_shd  <= '0;
      r_act  <= '0;
      r_pend <= 1'b0;
    end else if (i_wrap) begin
      if (i_bypass) begin
        r_act  <= i_mask;
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_act  <= r_shd;
        r_pend <= 1'b0;
      end
    end else if (i_wr) begin
      r_shd  <= i_mask;
      r_pend <= 1'b1;
    end
  end

  always_comb begin
    o_committed = i_wrap & (i_bypass | r_pend);
    o_skip      = i_e & r_act[i_pos] & (i_pos != LW'(PHASE0));
  end

endmodule

// File: rtl/skipseq.sv
// Multi-channel clock pulse swallower: phase ring, per-channel skip masks, gated clocks.
module skipseq import skipseq_pkg::*; #(
  parameter int unsigned LEN = 16,
  parameter int unsigned NCH = 2,
  parameter int unsigned LW  = clog2(LEN),
  parameter int unsigned CHW = chw_of(NCH)
) (
  input  logic           iCLK,
  input  logic           RST,
  input  logic           E,
  input  logic [LW-1:0]  PLEN,
  input  logic [LEN-1:0] MASK_IN,
  input  logic [CHW-1:0] CH_SEL,
  input  logic           LD,
  output logic           LD_ACK,
  output logic [NCH-1:0] oCLK,
  output logic [NCH-1:0] oCE,
  output logic           oB0,
  output logic [LW-1:0]  oPOS
);

  logic [LW-1:0]  r_pos;
  logic [LW-1:0]  r_plen;
  logic           r_ack;
  logic [LW-1:0]  w_plen_lim;
  logic           w_wrap;
  logic [NCH-1:0] w_wr;
  logic [NCH-1:0] w_bypass;
  logic [NCH-1:0] w_skip;
  logic [NCH-1:0] w_commit;

  // Ring lengths beyond the mask width would address nonexistent mask bits.
  always_comb begin
    w_plen_lim = PLEN;
    if (32'(PLEN) > LEN - 1) begin
      w_plen_lim = LW'(LEN - 1);
    end
    w_wrap = (r_pos == r_plen);
  end

  always_ff @(negedge iCLK) begin
    if (RST) begin
      r_pos  <= '0;
      r_plen <= w_plen_lim;
      r_ack  <= 1'b0;
    end else begin
      r_pos <= w_wrap ? '0 : r_pos + LW'(1);
      if (w_wrap) begin
        r_plen <= w_plen_lim;
      end
      r_ack <= |w_commit;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign w_wr[c]     = LD && (CH_SEL == CHW'(c));
    assign w_bypass[c] = w_wr[c] & w_wrap;

    skipseq_chan #(
      .LEN (LEN),
      .LW  (LW)
    ) u_chan (
      .i_clk       (iCLK),
      .i_rst       (RST),
      .i_wr        (w_wr[c]),
      .i_wrap      (w_wrap),
      .i_bypass    (w_bypass[c]),
      .i_e         (E),
      .i_mask      (MASK_IN),
      .i_pos       (r_pos),
      .o_skip      (w_skip[c]),
      .o_committed (w_commit[c])
    );
  end

  always_comb begin
    oCLK   = {NCH{iCLK}} & ~w_skip;
    oCE    = ~w_skip;
    oB0    = (r_pos == LW'(PHASE0));
    oPOS   = r_pos;
    LD_ACK = r_ack;
  end

endmodule

// File: tb/tb_skipseq.sv
// Directed bench for skipseq with a behavioural reference model feeding a scoreboard queue.
module tb_skipseq;

  localparam int NCH = 3;

  logic        iCLK = 1'b1;
  logic        RST, E, LD, LD_ACK, oB0;
  logic [3:0]  PLEN, oPOS;
  logic [15:0] MASK_IN;
  logic [1:0]  CH_SEL;
  logic [2:0]  oCLK, oCE;

  // Second instance: ring length not a power of two, single channel.
  logic        E2, LD2, LD_ACK2, oB02;
  logic [3:0]  PLEN2, oPOS2;
  logic [11:0] MASK2;
  logic [0:0]  CH_SEL2, oCLK2, oCE2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]       pos;
    logic             ack;
    logic [2:0][15:0] act;
  } exp_t;

  exp_t sb[$];

  logic [3:0]       m_pos  = '0;
  logic [3:0]       m_plen = '0;
  logic [2:0][15:0] m_act  = '0;
  logic [2:0][15:0] m_shd  = '0;
  logic [2:0]       m_pend = '0;

  always #5 iCLK = ~iCLK;

  skipseq #(.LEN(16), .NCH(NCH)) dut (
    .iCLK (iCLK), .RST (RST), .E (E), .PLEN (PLEN), .MASK_IN (MASK_IN),
    .CH_SEL (CH_SEL), .LD (LD), .LD_ACK (LD_ACK), .oCLK (oCLK), .oCE (oCE),
    .oB0 (oB0), .oPOS (oPOS)
  );

  skipseq #(.LEN(12), .NCH(1)) dut2 (
    .iCLK (iCLK), .RST (RST), .E (E2), .PLEN (PLEN2), .MASK_IN (MASK2),
    .CH_SEL (CH_SEL2), .LD (LD2), .LD_ACK (LD_ACK2), .oCLK (oCLK2), .oCE (oCE2),
    .oB0 (oB02), .oPOS (oPOS2)
  );

  // Reference model, evaluated on the same falling edge the DUT uses.
  always @(negedge iCLK) begin : model
    logic [3:0]       np, nplen;
    logic [2:0][15:0] na, ns;
    logic [2:0]       npd;
    logic             nack;
    np = m_pos; nplen = m_plen; na = m_act; ns = m_shd; npd = m_pend; nack = 1'b0;
    if (RST) begin
      np = '0; nplen = PLEN; na = '0; ns = '0; npd = '0;
    end else if (m_pos == m_plen) begin
      np = '0;
      nplen = PLEN;
      for (int c = 0; c < NCH; c++) begin
        if (LD && int'(CH_SEL) == c) begin
          na[c] = MASK_IN; npd[c] = 1'b0; nack = 1'b1;
        end else if (m_pend[c]) begin
          na[c] = m_shd[c]; npd[c] = 1'b0; nack = 1'b1;
        end
      end
    end else begin
      np = m_pos + 4'd1;
      if (LD && int'(CH_SEL) < NCH) begin
        ns[CH_SEL] = MASK_IN; npd[CH_SEL] = 1'b1;
      end
    end
    m_pos <= np; m_plen <= nplen; m_act <= na; m_shd <= ns; m_pend <= npd;
    sb.push_back('{pos: np, ack: nack, act: na});
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: wait past the rising edge, then compare against the scoreboard head.
  task automatic tick();
    exp_t       e;
    logic [2:0] ce;
    @(posedge iCLK);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected one entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int c = 0; c < NCH; c++) ce[c] = !(E && e.act[c][e.pos] && e.pos != 4'd0);
      checks++;
      assert (oPOS === e.pos) else begin
        errors++;
        $error("FAIL pos: observed %0d expected %0d", oPOS, e.pos);
      end
      checks++;
      assert ({oB0, LD_ACK} === {e.pos == 4'd0, e.ack}) else begin
        errors++;
        $error("FAIL b0_ack: observed %b%b expected %b%b", oB0, LD_ACK, e.pos == 4'd0, e.ack);
      end
      checks++;
      assert ({oCE, oCLK} === {ce, ce}) else begin
        errors++;
        $error("FAIL ce_clk: observed %b/%b expected %b/%b", oCE, oCLK, ce, ce);
      end
    end
  endtask

  task automatic wait_pos(input logic [3:0] p);
    for (int i = 0; i < 20; i++) begin
      if (oPOS === p) break;
      tick();
    end
    chk("wait_pos", int'(oPOS), int'(p));
  endtask

  initial begin
    int cnt, cnt2, mx;
    RST = 1'b1; E = 1'b1; PLEN = 4'd3; LD = 1'b0; CH_SEL = '0; MASK_IN = '0;
    E2 = 1'b1; PLEN2 = 4'd14; LD2 = 1'b1; CH_SEL2 = 1'b1; MASK2 = 12'hFFF;
    #2;
    tick(); tick();
    RST = 1'b0;
    chk("reset_pos", int'(oPOS), 0);
    chk("reset_ce", int'(oCE), 7);

    // Free-running ring of 4, no loads.
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(oB0); cnt2 += int'(LD_ACK); end
    chk("b0_per_rev", cnt, 1);
    chk("ack_idle", cnt2, 0);

    // Mid-revolution load commits at wrap.
    wait_pos(4'd1);
    LD = 1'b1; CH_SEL = 2'd0; MASK_IN = 16'h0002;
    tick();
    LD = 1'b0;
    chk("ce0_before_commit", int'(oCE[0]), 1);
    wait_pos(4'd0);
    chk("ack_after_commit", int'(LD_ACK), 1);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(!oCE[0]); cnt2 += int'(!oCE[1]); end
    chk("ch0_skips", cnt, 1);
    chk("ch1_skips", cnt2, 0);

    // All-ones mask on ch1, then gating disabled.
    LD = 1'b1; CH_SEL = 2'd1; MASK_IN = 16'hFFFF;
    tick();
    LD = 1'b0;
    wait_pos(4'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(oCLK[1]); end
    chk("ch1_pulses", cnt, 1);
    E = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin tick(); cnt += int'(oCE[1]); end
    chk("ch1_ce_disabled", cnt, 4);
    E = 1'b1;

    // Ring length change mid-revolution only applies after wrap.
    wait_pos(4'd2);
    PLEN = 4'd7;
    tick(); tick();
    chk("wrap_after_3", int'(oPOS), 0);
    mx = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (int'(oPOS) > mx) mx = int'(oPOS); end
    chk("max_pos_8", mx, 7);

    // Load exactly on the wrap edge bypasses the shadow.
    wait_pos(4'd7);
    LD = 1'b1; CH_SEL = 2'd0; MASK_IN = 16'h0004;
    tick();
    LD = 1'b0;
    chk("bypass_ack", int'(LD_ACK), 1);
    wait_pos(4'd2);
    chk("bypass_skip_pos2", int'(oCE[0]), 0);

    // Out-of-range channel select is ignored.
    LD = 1'b1; CH_SEL = 2'd3; MASK_IN = 16'hFFFF;
    tick();
    LD = 1'b0; CH_SEL = 2'd0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); cnt += int'(LD_ACK); end
    chk("bad_chan_no_ack", cnt, 0);

    // Reset with a pending load discards it.
    wait_pos(4'd1);
    LD = 1'b1; CH_SEL = 2'd0; MASK_IN = 16'hFFFF;
    tick();
    LD = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_pos", int'(oPOS), 0);
    chk("rst_ce", int'(oCE), 7);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); cnt += int'(LD_ACK); end
    chk("rst_no_commit", cnt, 0);

    // Second instance: PLEN 14 clamps to 11 (period 12), invalid loads never ack.
    cnt = 0; cnt2 = 0; mx = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      cnt += int'(oB02);
      cnt2 += int'(LD_ACK2) + int'(!oCE2[0]);
      if (int'(oPOS2) > mx) mx = int'(oPOS2);
    end
    chk("clamp_b0_count", cnt, 2);
    chk("clamp_max_pos", mx, 11);
    chk("dut2_no_ack_no_skip", cnt2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
